// File: rtl/adder_pkg.sv
// Shared definitions for the four-operand adder sequencer: state encoding,
// datapath select codes and the per-state strobe decode.
package adder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ADD_AB  = 3'd2,
    ST_ADD_C   = 3'd3,
    ST_ADD_D   = 3'd4,
    ST_PUBLISH = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [1:0] BSEL_AB  = 2'b00;
  localparam logic [1:0] BSEL_C   = 2'b01;
  localparam logic [1:0] BSEL_D   = 2'b10;
  localparam logic [1:0] BSEL_NOP = 2'b11;

  localparam logic ASEL_AB  = 1'b1;
  localparam logic ASEL_NOP = 1'b0;

  typedef struct packed {
    logic       load;
    logic       asel;
    logic [1:0] bsel;
    logic       oe;
    logic       busy;
    logic       done;
  } strobes_t;

  // Every state requests at most one datapath operation; anything not listed is a no-op.
  function automatic strobes_t decodeStrobes(input state_t s);
    strobes_t r;
    r.load = 1'b0;
    r.asel = ASEL_NOP;
    r.bsel = BSEL_NOP;
    r.oe   = 1'b0;
    r.busy = (s != ST_IDLE);
    r.done = (s == ST_DONE);
    case (s)
      ST_LOAD:    r.load = 1'b1;
      ST_ADD_AB: begin
        r.asel = ASEL_AB;
        r.bsel = BSEL_AB;
      end
      ST_ADD_C:   r.bsel = BSEL_C;
      ST_ADD_D:   r.bsel = BSEL_D;
      ST_PUBLISH: r.oe = 1'b1;
      default:    r.load = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adder_seq_counter.sv
// Generic wrapping up-counter with enable and asynchronous active-low clear.
module adder_seq_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/adder_sequencer.sv
// Control FSM for the four-operand adder datapath: loads operands, steps the
// accumulate selects, publishes the sum and reports completion to the host.
module adder_sequencer
  import adder_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DONE_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             add_c_en,
  input  logic             add_d_en,
  output logic             aload,
  output logic             bload,
  output logic             cload,
  output logic             dload,
  output logic             asel,
  output logic [1:0]       bsel,
  output logic             output_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] run_count
);

  localparam logic [3:0] HOLD_LAST = 4'(DONE_HOLD - 1);

  state_t   r_state;
  state_t   w_nextState;
  strobes_t r_strobes;
  logic     r_cEn;
  logic     r_dEn;
  logic [3:0] r_holdCnt;
  logic     w_doneEntry;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:    if (start && !abort) w_nextState = ST_LOAD;
      ST_LOAD:    w_nextState = abort ? ST_IDLE : ST_ADD_AB;
      ST_ADD_AB: begin
        if (abort)      w_nextState = ST_IDLE;
        else if (r_cEn) w_nextState = ST_ADD_C;
        else if (r_dEn) w_nextState = ST_ADD_D;
        else            w_nextState = ST_PUBLISH;
      end
      ST_ADD_C: begin
        if (abort)      w_nextState = ST_IDLE;
        else if (r_dEn) w_nextState = ST_ADD_D;
        else            w_nextState = ST_PUBLISH;
      end
      ST_ADD_D:   w_nextState = abort ? ST_IDLE : ST_PUBLISH;
      ST_PUBLISH: w_nextState = abort ? ST_IDLE : ST_DONE;
      ST_DONE:    if (r_holdCnt == 4'd0) w_nextState = ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  assign w_doneEntry = (r_state == ST_PUBLISH) && (w_nextState == ST_DONE);

  // Strobes are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_strobes <= decodeStrobes(ST_IDLE);
      r_cEn     <= 1'b0;
      r_dEn     <= 1'b0;
      r_holdCnt <= 4'd0;
    end else begin
      r_state   <= w_nextState;
      r_strobes <= decodeStrobes(w_nextState);
      if (r_state == ST_IDLE && w_nextState == ST_LOAD) begin
        r_cEn <= add_c_en;
        r_dEn <= add_d_en;
      end
      if (w_doneEntry) begin
        r_holdCnt <= HOLD_LAST;
      end else if (r_state == ST_DONE && r_holdCnt != 4'd0) begin
        r_holdCnt <= r_holdCnt - 4'd1;
      end
    end
  end

  adder_seq_counter #(
    .CNT_W (CNT_W)
  ) u_runCounter (
    .i_clk   (clk),
    .i_clr_n (rst),
    .i_en    (w_doneEntry),
    .o_count (run_count)
  );

  assign aload         = r_strobes.load;
  assign bload         = r_strobes.load;
  assign cload         = r_strobes.load;
  assign dload         = r_strobes.load;
  assign asel          = r_strobes.asel;
  assign bsel          = r_strobes.bsel;
  assign output_enable = r_strobes.oe;
  assign busy          = r_strobes.busy;
  assign done          = r_strobes.done;

endmodule
